// File: rtl/dmem_access_ctrl.sv
// Sequences single CPU load/store requests onto the DMEM tri-state port:
// address setup, programmable wait states, and a bus-turnaround cycle after stores.
module dmem_access_ctrl #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ack,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_busy,
  output logic                  drive_enable,
  output logic [DATA_WIDTH-1:0] drive_value,
  output logic [ADDR_WIDTH-1:0] current_addr,
  input  logic [DATA_WIDTH-1:0] current_value
);

  // state  | meaning
  // IDLE   | waiting for cpu_req
  // SETUP  | address presented, bus released
  // ACCESS | WAIT_STATES+1 cycles; stores drive the bus, loads sample at the end
  // TURN   | stores only: bus released before anyone else may drive it
  // DONE   | one-cycle cpu_ack
  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, TURN, DONE} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  state_t                  state, state_nx;
  logic [3:0]              wait_cnt;
  logic                    we_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    accept;
  logic                    last_access;

  assign accept      = (state == IDLE) && cpu_req;
  assign last_access = (state == ACCESS) && (wait_cnt == 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (cpu_req) state_nx = SETUP;
      SETUP:   state_nx = ACCESS;
      ACCESS:  if (wait_cnt == 4'd0) state_nx = we_q ? TURN : DONE;
      TURN:    state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt     <= 4'd0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      current_addr <= '0;
      drive_value  <= '0;
      drive_enable <= 1'b0;
      cpu_rdata    <= '0;
      cpu_ack      <= 1'b0;
      cpu_busy     <= 1'b0;
    end else begin
      if (accept) begin
        we_q         <= cpu_we;
        wdata_q      <= cpu_wdata;
        current_addr <= cpu_addr;
      end
      if (state == SETUP)
        wait_cnt <= WAIT_INIT;
      else if ((state == ACCESS) && (wait_cnt != 4'd0))
        wait_cnt <= wait_cnt - 4'd1;
      if (last_access && !we_q)
        cpu_rdata <= current_value;
      drive_enable <= (state_nx == ACCESS) && we_q;
      if ((state_nx == ACCESS) && we_q)
        drive_value <= wdata_q;
      cpu_ack  <= (state_nx == DONE);
      cpu_busy <= (state_nx != IDLE);
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed table, hand-written corner
// sequences and randomized ops against a transaction-level memory model.
module tb_dmem_access_ctrl;
  localparam int W = 1;

  logic        clk, rst;
  logic        req, we, ack, busy, de;
  logic [7:0]  addr, caddr;
  logic [15:0] wdata, rdata, dv, cval;

  logic [15:0] mem [256];
  logic [15:0] ref_mem [256];

  int total = 0;
  int bad   = 0;

  dmem_access_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .WAIT_STATES(W)) dut (
    .clk(clk), .rst(rst), .cpu_req(req), .cpu_we(we), .cpu_addr(addr),
    .cpu_wdata(wdata), .cpu_ack(ack), .cpu_rdata(rdata), .cpu_busy(busy),
    .drive_enable(de), .drive_value(dv), .current_addr(caddr),
    .current_value(cval));

  // Port model: write on the clock while driven, read combinationally.
  always @(posedge clk) if (de) mem[caddr] <= dv;
  assign cval = mem[caddr];

  // Two extra instances for the wait-state extremes, with a read-only port.
  logic        req_x [2];
  logic        we_x  [2];
  logic        ack_x [2];
  logic        busy_x[2];
  logic        de_x  [2];
  logic [7:0]  addr_x[2];
  logic [7:0]  caddr_x[2];
  logic [15:0] wdata_x[2];
  logic [15:0] rdata_x[2];
  logic [15:0] dv_x[2];
  logic [15:0] cval_x[2];

  dmem_access_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .WAIT_STATES(0)) dut_w0 (
    .clk(clk), .rst(rst), .cpu_req(req_x[0]), .cpu_we(we_x[0]), .cpu_addr(addr_x[0]),
    .cpu_wdata(wdata_x[0]), .cpu_ack(ack_x[0]), .cpu_rdata(rdata_x[0]),
    .cpu_busy(busy_x[0]), .drive_enable(de_x[0]), .drive_value(dv_x[0]),
    .current_addr(caddr_x[0]), .current_value(cval_x[0]));

  dmem_access_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .WAIT_STATES(15)) dut_w15 (
    .clk(clk), .rst(rst), .cpu_req(req_x[1]), .cpu_we(we_x[1]), .cpu_addr(addr_x[1]),
    .cpu_wdata(wdata_x[1]), .cpu_ack(ack_x[1]), .cpu_rdata(rdata_x[1]),
    .cpu_busy(busy_x[1]), .drive_enable(de_x[1]), .drive_value(dv_x[1]),
    .current_addr(caddr_x[1]), .current_value(cval_x[1]));

  assign cval_x[0] = {8'hA5, caddr_x[0]};
  assign cval_x[1] = {8'hA5, caddr_x[1]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          st;
    logic [7:0]  a;
    logic [15:0] d;
    int          exp_lat;
    logic [15:0] exp_rd;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] init_val(input int i);
    return 16'(i * 257) ^ 16'hC3C3;
  endfunction

  // One complete transaction from IDLE; lat counts edges from accept to ack.
  // After accept the request inputs are scrambled to prove they were latched.
  task automatic do_op(input bit st, input logic [7:0] a, input logic [15:0] d,
                       output int lat, output logic [15:0] rd,
                       output int de_cnt, output int bad_dv);
    req = 1'b1; we = st; addr = a; wdata = d;
    step();
    addr = 8'($urandom); wdata = 16'($urandom); we = 1'($urandom);
    if ($urandom_range(0, 1) == 1) req = 1'b0;
    lat = 0; de_cnt = 0; bad_dv = 0;
    while (!ack && lat < 40) begin
      if (de) begin
        de_cnt++;
        if (dv !== d || caddr !== a) bad_dv++;
      end
      step();
      lat++;
    end
    if (lat >= 40) chk("ack_timeout", 0, 1);
    rd = rdata;
    req = 1'b0;
    if (st) ref_mem[a] = d;
    step();
  endtask

  task automatic lat_test(input int idx, input int w);
    int bc, al, acks, dec;
    req_x[idx] = 1'b1; we_x[idx] = 1'b0; addr_x[idx] = 8'h4B; wdata_x[idx] = 16'h0;
    step();
    req_x[idx] = 1'b0;
    bc = 0; al = -1; acks = 0; dec = 0;
    for (int k = 0; k < 40; k++) begin
      if (busy_x[idx]) bc++;
      if (de_x[idx]) dec++;
      if (ack_x[idx]) begin
        acks++;
        if (al < 0) al = k;
      end
      if (!busy_x[idx] && k > 0) break;
      step();
    end
    chk($sformatf("w%0d_ack_lat", w), al, 2 + w);
    chk($sformatf("w%0d_busy_cycles", w), bc, 3 + w);
    chk($sformatf("w%0d_ack_count", w), acks, 1);
    chk($sformatf("w%0d_drive_enable", w), dec, 0);
    chk($sformatf("w%0d_rdata", w), rdata_x[idx], {8'hA5, 8'h4B});
  endtask

  vec_t vecs[6];

  initial begin
    int lat, dec, bdv, k;
    logic [15:0] rd, orig;

    for (int i = 0; i < 256; i++) begin
      mem[i] = init_val(i);
      ref_mem[i] = init_val(i);
    end
    for (int i = 0; i < 2; i++) begin
      req_x[i] = 1'b0; we_x[i] = 1'b0; addr_x[i] = 8'h0; wdata_x[i] = 16'h0;
    end

    // Reset held with a request pending: nothing accepted, all outputs zero.
    rst = 1'b1; req = 1'b1; we = 1'b0; addr = 8'h3C; wdata = 16'h0;
    repeat (4) step();
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_de", de, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_dv", dv, 0);
    chk("rst_caddr", caddr, 0);
    rst = 1'b0;
    step();
    chk("first_accept_busy", busy, 1);
    chk("first_accept_addr", caddr, 8'h3C);
    k = 0;
    while (!ack && k < 40) begin step(); k++; end
    chk("first_op_lat", k, 2 + W);
    req = 1'b0;
    step();

    // Directed table (W=1).
    vecs[0] = '{1'b1, 8'h3C, 16'hBEEF, 3 + W, 16'h0};
    vecs[1] = '{1'b0, 8'h3C, 16'h0,    2 + W, 16'hBEEF};
    vecs[2] = '{1'b1, 8'h10, 16'h1234, 3 + W, 16'h0};
    vecs[3] = '{1'b0, 8'h10, 16'h0,    2 + W, 16'h1234};
    vecs[4] = '{1'b0, 8'h77, 16'h0,    2 + W, 16'hB4B4};
    vecs[5] = '{1'b1, 8'h01, 16'hFFFF, 3 + W, 16'h0};
    foreach (vecs[i]) begin
      do_op(vecs[i].st, vecs[i].a, vecs[i].d, lat, rd, dec, bdv);
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
      chk($sformatf("vec%0d_de_cycles", i), dec, vecs[i].st ? W + 1 : 0);
      chk($sformatf("vec%0d_drive_value", i), bdv, 0);
      if (!vecs[i].st) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
    end

    // Load result held long after completion.
    do_op(1'b0, 8'h3C, 16'h0, lat, rd, dec, bdv);
    repeat (10) step();
    chk("rdata_hold", rdata, 16'hBEEF);

    // Back-to-back store then load with cpu_req held high throughout.
    req = 1'b1; we = 1'b1; addr = 8'h10; wdata = 16'h1234;
    step();
    k = 0;
    while (!ack && k < 40) begin step(); k++; end
    chk("b2b_store_lat", k, 3 + W);
    we = 1'b0;
    step();
    chk("b2b_idle_gap", busy, 0);
    step();
    chk("b2b_second_accept", busy, 1);
    req = 1'b0;
    k = 0;
    while (!ack && k < 40) begin
      if (de) chk("b2b_load_de", de, 0);
      step(); k++;
    end
    chk("b2b_load_lat", k, 2 + W);
    chk("b2b_load_rdata", rdata, 16'h1234);
    step();

    // Reset in the first ACCESS cycle of a store aborts it before any write.
    orig = mem[8'h20];
    req = 1'b1; we = 1'b1; addr = 8'h20; wdata = 16'hFFFF;
    step();
    req = 1'b0;
    step();
    chk("abort_de_before", de, 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_de_async", de, 0);
    chk("abort_rdata_cleared", rdata, 0);
    k = 0;
    repeat (3) begin step(); if (ack) k++; end
    rst = 1'b0;
    repeat (6) begin step(); if (ack) k++; end
    chk("abort_no_ack", k, 0);
    do_op(1'b0, 8'h20, 16'h0, lat, rd, dec, bdv);
    chk("abort_load_orig", rd, orig);

    // Wait-state extremes.
    lat_test(0, 0);
    lat_test(1, 15);

    // Randomized ops against the transaction-level model.
    for (int i = 0; i < 40; i++) begin
      bit st;
      logic [7:0] a;
      logic [15:0] d, exp;
      st = 1'($urandom);
      a = 8'($urandom_range(0, 7));
      d = 16'($urandom);
      exp = ref_mem[a];
      do_op(st, a, d, lat, rd, dec, bdv);
      chk($sformatf("rnd%0d_lat", i), lat, st ? 3 + W : 2 + W);
      chk($sformatf("rnd%0d_de_cycles", i), dec, st ? W + 1 : 0);
      chk($sformatf("rnd%0d_drive_value", i), bdv, 0);
      if (!st) chk($sformatf("rnd%0d_rdata", i), rd, exp);
      if ($urandom_range(0, 2) == 0) step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
